mem_burst_arbiter: RTL and testbench

- Shares the single word-wide main data memory between the instruction-cache refill port (I, read-only) and the data-cache miss port (D, refill or dirty-line writeback).
- Grants whole-line bursts of LINE_WORDS beats, one beat per cycle, with round-robin fairness.
- Sequences the beat counter and drives the memory address, write data and write enable, so neither cache needs its own memory sequencing.
- Sits between both cache controllers and data_mem; memory read is combinational, memory write is on the clock edge.

---
 rtl/mem_burst_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_burst_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter: shares one word-wide data memory between the I-cache
// refill port and the D-cache miss port. Whole-line bursts of LINE_WORDS
// beats, one per cycle, round-robin between the two ports.
module mem_burst_arbiter #(
  parameter int LINE_WORDS  = 4,
  parameter int BEAT_BITS   = 2,
  parameter int OFFSET_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  // I port (read-only refill)
  input  logic                 i_req,
  input  logic [31:0]          i_addr,
  output logic                 i_gnt,
  output logic                 i_rvalid,
  output logic                 i_done,
  // D port (refill or writeback)
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [31:0]          d_addr,
  input  logic [31:0]          d_wdata,
  output logic                 d_gnt,
  output logic                 d_rvalid,
  output logic                 d_done,
  // shared beat index and read data
  output logic [BEAT_BITS-1:0] i_beat,
  output logic [BEAT_BITS-1:0] d_beat,
  output logic [31:0]          rdata,
  // memory side
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 mem_we,
  input  logic [31:0]          mem_rdata,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int                 LINE_BITS = 32 - OFFSET_BITS;
  localparam logic [BEAT_BITS-1:0] LAST_BEAT = BEAT_BITS'(LINE_WORDS - 1);

  // owner encoding: 0 = I port, 1 = D port
  state_e               state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [BEAT_BITS-1:0] beat_q, beat_d;
  logic [LINE_BITS-1:0] line_q, line_d;
  logic                 we_q, we_d;

  // Line offset bits of the request addresses are deliberately dropped.
  logic unused_offset;
  assign unused_offset = ^{i_addr[OFFSET_BITS-1:0], d_addr[OFFSET_BITS-1:0]};

  // State register; reset abandons any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;  // I wins the first tie
      beat_q       <= '0;
      line_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_q       <= beat_d;
      line_q       <= line_d;
      we_q         <= we_d;
    end
  end

  // Next-state: registered grant in IDLE, beat sequencing in BURST,
  // fairness bookkeeping in DONE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_d       = beat_q;
    line_d       = line_q;
    we_d         = we_q;
    unique case (state_q)
      IDLE: begin
        // I wins if alone, or if both ask and D went last.
        if (i_req && (!d_req || last_owner_q)) begin
          owner_d = 1'b0;
          we_d    = 1'b0;
          line_d  = i_addr[31:OFFSET_BITS];
          beat_d  = '0;
          state_d = BURST;
        end else if (d_req) begin
          owner_d = 1'b1;
          we_d    = d_we;
          line_d  = d_addr[31:OFFSET_BITS];
          beat_d  = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        // Counter wraps through its width, so it is back to 0 in DONE.
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        last_owner_d = owner_q;
        state_d      = IDLE;  // always one dead IDLE cycle between bursts
      end
      default: state_d = IDLE;
    endcase
  end

  logic in_burst, owned;
  assign in_burst = (state_q == BURST);
  assign owned    = (state_q != IDLE);

  // Memory drive and per-port handshakes, gated to the current owner.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (in_burst) begin
      mem_addr = {line_q, {OFFSET_BITS{1'b0}}} | 32'({beat_q, 2'b00});
      if (we_q) begin
        mem_we    = 1'b1;
        mem_wdata = d_wdata;
      end
    end
  end

  assign i_gnt    = owned && !owner_q;
  assign d_gnt    = owned &&  owner_q;
  assign i_rvalid = in_burst && !we_q && !owner_q;
  assign d_rvalid = in_burst && !we_q &&  owner_q;
  assign i_done   = (state_q == DONE) && !owner_q;
  assign d_done   = (state_q == DONE) &&  owner_q;
  assign i_beat   = beat_q;
  assign d_beat   = beat_q;
  assign rdata    = mem_rdata;
  assign busy     = owned;

  // Only one port can ever own the memory, and writes only happen in BURST.
  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) !(i_gnt && d_gnt));
  a_we_burst:   assert property (@(posedge clk) disable iff (rst) mem_we |-> in_burst);

endmodule

// File: tb/tb_mem_burst_arbiter.sv
// Directed bench for mem_burst_arbiter: inputs change and outputs are sampled
// on the falling edge; a small word memory sits behind the memory port.
module tb_mem_burst_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic        i_gnt, i_rvalid, i_done, d_gnt, d_rvalid, d_done;
  logic [1:0]  i_beat, d_beat;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  // backdoor preload port for the memory model
  logic        bk_we;
  logic [31:0] bk_addr, bk_dat;

  logic [31:0] mem [0:4095] = '{default: 32'h0};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_burst_arbiter #(.LINE_WORDS(4), .BEAT_BITS(2), .OFFSET_BITS(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_done(i_done),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_done(d_done),
    .i_beat(i_beat), .d_beat(d_beat), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // D-cache writeback data is a function of the beat, combinationally.
  assign d_wdata   = 32'hA0 + 32'(d_beat);
  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_we)     mem[mem_addr[13:2]] <= mem_wdata;
    else if (bk_we) mem[bk_addr[13:2]]  <= bk_dat;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; bk_we = 1'b0; bk_addr = '0; bk_dat = '0;
    nxt();
    // preload the refill line while the arbiter is held in reset
    for (int k = 0; k < 4; k++) begin
      bk_we = 1'b1; bk_addr = 32'h1230 + 32'(4*k); bk_dat = 32'hC0DE_0000 + 32'(k);
      nxt();
    end
    bk_we = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_i_gnt", i_gnt, 0);
    chk("rst_d_gnt", d_gnt, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_beat", d_beat, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    nxt();

    // ---- refill ----
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_1238;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("rf_addr", mem_addr, 32'h1230 + 32'(4*k));
      chk("rf_rvalid", d_rvalid, 1);
      chk("rf_beat", d_beat, k);
      chk("rf_we", mem_we, 0);
      chk("rf_rdata", rdata, 32'hC0DE_0000 + 32'(k));
      chk("rf_i_gnt", i_gnt, 0);
      if (k == 0) d_req = 1'b0;
    end
    nxt();
    chk("rf_done", d_done, 1);
    chk("rf_done_gnt", d_gnt, 1);
    chk("rf_done_we", mem_we, 0);
    chk("rf_done_rvalid", d_rvalid, 0);
    nxt();
    chk("rf_idle_busy", busy, 0);
    chk("rf_idle_done", d_done, 0);

    // ---- writeback ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_2000;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("wb_we", mem_we, 1);
      chk("wb_wdata", mem_wdata, 32'hA0 + 32'(k));
      chk("wb_addr", mem_addr, 32'h2000 + 32'(4*k));
      chk("wb_rvalid", d_rvalid, 0);
      // d_we flips mid-burst; the latched flag must keep the write going
      if (k == 0) begin d_req = 1'b0; d_we = 1'b0; end
    end
    nxt();
    chk("wb_done_we", mem_we, 0);
    chk("wb_done", d_done, 1);
    nxt();
    chk("wb_idle_we", mem_we, 0);
    for (int k = 0; k < 4; k++) chk("wb_mem", mem[(32'h2000 >> 2) + k], 32'hA0 + 32'(k));

    // ---- tie after reset ----
    rst = 1'b1; nxt(); rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; i_addr = 32'h4000; d_addr = 32'h5004;
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("tie_i_gnt", i_gnt, 1);
      chk("tie_d_gnt", d_gnt, 0);
      chk("tie_i_rvalid", i_rvalid, 1);
      chk("tie_d_rvalid", d_rvalid, 0);
      chk("tie_i_addr", mem_addr, 32'h4000 + 32'(4*k));
    end
    nxt();
    chk("tie_i_done", i_done, 1);
    chk("tie_d_done0", d_done, 0);
    chk("tie_d_gnt_done", d_gnt, 0);
    i_req = 1'b0;
    nxt();
    chk("tie_idle_busy", busy, 0);
    chk("tie_idle_d_gnt", d_gnt, 0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("tie_d_gnt2", d_gnt, 1);
      chk("tie_i_gnt2", i_gnt, 0);
      chk("tie_d_rvalid2", d_rvalid, 1);
      chk("tie_d_beat", d_beat, k);
      chk("tie_d_addr", mem_addr, 32'h5000 + 32'(4*k));
      if (k == 0) d_req = 1'b0;
    end
    nxt();
    chk("tie_d_done", d_done, 1);
    chk("tie_i_done2", i_done, 0);
    nxt();

    // ---- fairness under continuous requests ----
    rst = 1'b1; nxt(); rst = 1'b0;
    i_req = 1'b1; d_req = 1'b1; i_addr = 32'h4000; d_addr = 32'h5000; d_we = 1'b0;
    for (int b = 0; b < 4; b++) begin
      nxt();
      chk("fair_i_gnt", i_gnt, 32'(b % 2 == 0));
      chk("fair_d_gnt", d_gnt, 32'(b % 2 == 1));
      for (int k = 0; k < 3; k++) nxt();
      nxt();
      chk("fair_i_done", i_done, 32'(b % 2 == 0));
      chk("fair_d_done", d_done, 32'(b % 2 == 1));
      nxt();
      chk("fair_idle", busy, 0);
    end
    i_req = 1'b0; d_req = 1'b0;
    nxt();

    // ---- reset in the middle of a writeback ----
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h3000;
    nxt();
    chk("mr_we0", mem_we, 1);
    nxt();
    chk("mr_beat1", d_beat, 1);
    rst = 1'b1;
    nxt();
    chk("mr_busy", busy, 0);
    chk("mr_we", mem_we, 0);
    chk("mr_d_gnt", d_gnt, 0);
    chk("mr_done", d_done, 0);
    rst = 1'b0; d_req = 1'b0; d_we = 1'b0;
    nxt();
    chk("mr_done2", d_done, 0);
    chk("mr_busy2", busy, 0);
    chk("mr_mem0", mem[32'h3000 >> 2], 32'hA0);
    chk("mr_mem1", mem[32'h3004 >> 2], 32'hA1);
    chk("mr_mem2", mem[32'h3008 >> 2], 32'h0);
    chk("mr_mem3", mem[32'h300C >> 2], 32'h0);

    // ---- held request through DONE ----
    i_req = 1'b1; i_addr = 32'h6000;
    for (int k = 0; k < 4; k++) nxt();
    nxt();
    chk("hold_done1", i_done, 1);
    nxt();
    chk("hold_idle_busy", busy, 0);
    chk("hold_idle_gnt", i_gnt, 0);
    nxt();
    chk("hold_regnt", i_gnt, 1);
    chk("hold_beat", i_beat, 0);
    chk("hold_addr", mem_addr, 32'h6000);
    for (int k = 0; k < 3; k++) nxt();
    nxt();
    chk("hold_done2", i_done, 1);
    i_req = 1'b0;
    nxt();
    chk("hold_end_busy", busy, 0);
    nxt();
    chk("hold_no_regnt_busy", busy, 0);
    chk("hold_no_regnt_gnt", i_gnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
